// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: request fields in, encoded word stream out.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [1:0]       alu_sel;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [12:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err;
  logic [CNT_W-1:0] enc_count;

  modport slave (
    input  in_valid, op, alu_sel, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_instr, err, enc_count
  );

  modport master (
    output in_valid, op, alu_sel, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_instr, err, enc_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I encoder for R-type/LW/SW/BEQ requests, queued in a small FIFO and
// streamed out; every output, including in_ready and the FIFO head, is registered.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0] CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  function automatic logic [31:0] encode(
    input logic [1:0]  op,
    input logic [1:0]  alu_sel,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] w;
    f3 = 3'b000;
    f7 = 7'b0000000;
    w  = 32'd0;
    case (op)
      2'd0: begin
        case (alu_sel)
          2'd0:    begin f3 = 3'b000; f7 = 7'b0000000; end
          2'd1:    begin f3 = 3'b000; f7 = 7'b0100000; end
          2'd2:    begin f3 = 3'b111; f7 = 7'b0000000; end
          2'd3:    begin f3 = 3'b110; f7 = 7'b0000000; end
          default: begin f3 = 3'b000; f7 = 7'b0000000; end
        endcase
        w = {f7, rs2, rs1, f3, rd, 7'd51};
      end
      2'd1:    w = {imm[11:0], rs1, 3'b010, rd, 7'd3};
      2'd2:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'd35};
      2'd3:    w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'd99};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  logic        reject_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [AW:0] remain_s;
  logic [31:0] word_s;

  // Handshake decode, FIFO bookkeeping and next head-of-queue selection.
  always_comb begin
    word_s      = encode(bus.op, bus.alu_sel, bus.rd, bus.rs1, bus.rs2, bus.imm);
    reject_s    = (bus.op == 2'd3) && bus.imm[0];
    accept_s    = bus.in_valid && in_ready_q;
    push_s      = accept_s && !reject_s;
    pop_s       = out_valid_q && bus.out_ready;
    err_d       = accept_s && reject_s;
    wr_ptr_d    = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    remain_s    = pop_s ? (count_q - CNT_ONE) : count_q;
    count_d     = push_s ? (remain_s + CNT_ONE) : remain_s;
    in_ready_d  = (count_d != DEPTH_C);
    out_valid_d = (count_d != CNT_ZERO);
    enc_count_d = pop_s ? (enc_count_q + CNT_W'(1)) : enc_count_q;
    // A word pushed into a queue that is empty after this cycle's pop becomes the head directly.
    if (count_d == CNT_ZERO) begin
      out_instr_d = 32'd0;
    end else if (remain_s == CNT_ZERO) begin
      out_instr_d = word_s;
    end else begin
      out_instr_d = mem_q[rd_ptr_d];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      err_q       <= 1'b0;
      enc_count_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= word_s;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.err       = err_q;
  assign bus.enc_count = enc_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, rejection, backpressure,
// steady push/pop, reset flush and counter wrap.
module tb_instr_encoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  instr_encoder_if #(.CNT_W(16)) bus ();

  instr_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  alu_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] op, input logic [1:0] alu, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    bus.op      = op;
    bus.alu_sel = alu;
    bus.rd      = rd;
    bus.rs1     = rs1;
    bus.rs2     = rs2;
    bus.imm     = imm;
  endtask

  function automatic logic [31:0] lw_word(input int i);
    return 32'h0000_2083 | (32'(i) << 20);
  endfunction

  initial begin
    int exp_cnt;
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{2'd0, 2'd0, 5'd1,  5'd2,  5'd3,  13'h0000, 32'h003100B3, 1'b0};
    vecs[1]  = '{2'd0, 2'd1, 5'd1,  5'd2,  5'd3,  13'h0000, 32'h403100B3, 1'b0};
    vecs[2]  = '{2'd0, 2'd2, 5'd1,  5'd2,  5'd3,  13'h1FFF, 32'h003170B3, 1'b0};
    vecs[3]  = '{2'd0, 2'd3, 5'd1,  5'd2,  5'd3,  13'h0000, 32'h003160B3, 1'b0};
    vecs[4]  = '{2'd1, 2'd3, 5'd5,  5'd10, 5'd31, 13'h0008, 32'h00852283, 1'b0};
    vecs[5]  = '{2'd2, 2'd1, 5'd31, 5'd10, 5'd5,  13'h000C, 32'h00552623, 1'b0};
    vecs[6]  = '{2'd3, 2'd0, 5'd0,  5'd1,  5'd2,  13'h1FF8, 32'hFE208CE3, 1'b0};
    vecs[7]  = '{2'd3, 2'd0, 5'd0,  5'd1,  5'd2,  13'h0005, 32'h00000000, 1'b1};
    vecs[8]  = '{2'd2, 2'd0, 5'd0,  5'd10, 5'd5,  13'h1FFC, 32'hFE552E23, 1'b0};
    vecs[9]  = '{2'd1, 2'd0, 5'd3,  5'd4,  5'd0,  13'h1FFF, 32'hFFF22183, 1'b0};
    vecs[10] = '{2'd3, 2'd2, 5'd7,  5'd1,  5'd2,  13'h0008, 32'h00208463, 1'b0};
    vecs[11] = '{2'd3, 2'd0, 5'd0,  5'd3,  5'd4,  13'h1FFF, 32'h00000000, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req(2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_instr", bus.out_instr, 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_enc_count", 32'(bus.enc_count), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Encoding table: one request at a time, drained immediately.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = 1'b1;
      set_req(vecs[i].op, vecs[i].alu_sel, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(!vecs[i].exp_err));
      if (!vecs[i].exp_err) check($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_cnt_pre", i), 32'(bus.enc_count), 32'(exp_cnt));
      step();
      if (!vecs[i].exp_err) exp_cnt++;
      check($sformatf("vec%0d_err_clear", i), 32'(bus.err), 32'd0);
      check($sformatf("vec%0d_drained", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("vec%0d_cnt_post", i), 32'(bus.enc_count), 32'(exp_cnt));
    end

    // Backpressure: two words fill the queue, third waits until a slot frees.
    bus.out_ready = 1'b0;
    set_req(2'd0, 2'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    bus.in_valid = 1'b1;
    step();
    check("bp_a_valid", 32'(bus.out_valid), 32'd1);
    check("bp_a_instr", bus.out_instr, 32'h003100B3);
    check("bp_a_ready", 32'(bus.in_ready), 32'd1);
    set_req(2'd0, 2'd1, 5'd1, 5'd2, 5'd3, 13'd0);
    step();
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    check("bp_b_instr_hold", bus.out_instr, 32'h003100B3);
    set_req(2'd0, 2'd2, 5'd1, 5'd2, 5'd3, 13'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      check("bp_stall_instr", bus.out_instr, 32'h003100B3);
      check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_drain_b", bus.out_instr, 32'h403100B3);
    check("bp_slot_free", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_drain_c", bus.out_instr, 32'h003170B3);
    check("bp_c_valid", 32'(bus.out_valid), 32'd1);
    step();
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_count", 32'(bus.enc_count), 32'(exp_cnt + 3));

    // Steady push/pop at occupancy one.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    set_req(2'd1, 2'd0, 5'd1, 5'd0, 5'd0, 13'd0);
    bus.in_valid = 1'b1;
    step();
    check("pp_first", bus.out_instr, lw_word(0));
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      set_req(2'd1, 2'd0, 5'd1, 5'd0, 5'd0, 13'(k));
      step();
      check($sformatf("pp%0d_instr", k), bus.out_instr, lw_word(k));
      check($sformatf("pp%0d_ready", k), 32'(bus.in_ready), 32'd1);
      check($sformatf("pp%0d_cnt", k), 32'(bus.enc_count), 32'(k));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check("pp_final_cnt", 32'(bus.enc_count), 32'd10);
    check("pp_final_head", bus.out_instr, lw_word(10));

    // Reset with two words queued discards everything.
    set_req(2'd1, 2'd0, 5'd1, 5'd0, 5'd0, 13'd11);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("rst_pre_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_cnt", 32'(bus.enc_count), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_instr", bus.out_instr, 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("rst_nothing_left", 32'(bus.out_valid), 32'd0);
    check("rst_cnt_hold", 32'(bus.enc_count), 32'd0);

    // Counter wrap: 65535 deliveries reach FFFF, one more wraps to zero.
    set_req(2'd0, 2'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      step();
    end
    check("wrap_ffff", 32'(bus.enc_count), 32'h0000FFFF);
    check("wrap_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("wrap_zero", 32'(bus.enc_count), 32'd0);
    check("wrap_empty", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
